// File: rtl/scope_pkg.sv
// Shared constants for the scope capture path: FSM state encodings and trigger edge select.
package scope_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE = 3'd0;
  localparam logic [STATE_W-1:0] PRE  = 3'd1;
  localparam logic [STATE_W-1:0] WAIT = 3'd2;
  localparam logic [STATE_W-1:0] POST = 3'd3;
  localparam logic [STATE_W-1:0] READ = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = IDLE,
    S_PRE  = PRE,
    S_WAIT = WAIT,
    S_POST = POST,
    S_READ = READ
  } state_e;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port with read enable.
module capture_ram #(
  parameter int unsigned pAddrBits = 9,
  parameter int unsigned pDataBits = 8
) (
  input  logic                 iClk,
  input  logic                 iWe,
  input  logic [pAddrBits-1:0] iWAddr,
  input  logic [pDataBits-1:0] iWData,
  input  logic                 iRe,
  input  logic [pAddrBits-1:0] iRAddr,
  output logic [pDataBits-1:0] oRData
);

  localparam int unsigned DEPTH = 2 ** pAddrBits;

  logic [pDataBits-1:0] mem_q [DEPTH];
  logic [pDataBits-1:0] rd_data_q;

  // Read data holds while iRe is low, which lets the reader stall without a skid copy.
  always_ff @(posedge iClk) begin
    if (iWe) mem_q[iWAddr] <= iWData;
    if (iRe) rd_data_q <= mem_q[iRAddr];
  end

  assign oRData = rd_data_q;

endmodule

// File: rtl/scope_capture_ctrl.sv
// Trigger/capture controller: ring-buffer capture with pre-trigger depth, level/forced trigger,
// and single-frame readout over a valid/ready stream.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int unsigned pAddrBits = 9,
  parameter int unsigned pDataBits = 8
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iArm,
  input  logic                 iForce,
  input  logic                 iEdge,
  input  logic [pDataBits-1:0] iLevel,
  input  logic [pAddrBits-1:0] iPreCnt,
  input  logic [pDataBits-1:0] iData,
  input  logic                 iData_Valid,
  output logic [pDataBits-1:0] oData,
  output logic                 oData_Valid,
  input  logic                 iData_Ready,
  output logic [2:0]           oState,
  output logic                 oTriggered,
  output logic                 oBusy
);

  localparam int unsigned CNT_W = pAddrBits + 1;
  localparam logic [CNT_W-1:0]     FRAME_LEN = CNT_W'(2 ** pAddrBits);
  localparam logic [pAddrBits-1:0] ADDR_MAX  = '1;

  state_e               state_q, state_d;
  logic                 edge_q, edge_d;
  logic [pDataBits-1:0] level_q, level_d;
  logic [pDataBits-1:0] prev_q, prev_d;
  logic                 prev_vld_q, prev_vld_d;
  logic [pAddrBits-1:0] pre_q, pre_d;
  logic [pAddrBits-1:0] wr_ptr_q, wr_ptr_d;
  logic [pAddrBits-1:0] cnt_q, cnt_d;
  logic [pAddrBits-1:0] rd_addr_q, rd_addr_d;
  logic                 force_q, force_d;
  logic                 trig_q, trig_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]     hs_cnt_q, hs_cnt_d;
  logic                 s1_vld_q, s1_vld_d;
  logic                 out_vld_q, out_vld_d;
  logic [pDataBits-1:0] out_data_q, out_data_d;

  logic                 we_c, re_c, level_hit_c, move_c, hs_c;
  logic [pDataBits-1:0] ram_rdata;

  capture_ram #(
    .pAddrBits (pAddrBits),
    .pDataBits (pDataBits)
  ) u_ram (
    .iClk   (iClk),
    .iWe    (we_c),
    .iWAddr (wr_ptr_q),
    .iWData (iData),
    .iRe    (re_c),
    .iRAddr (rd_addr_q),
    .oRData (ram_rdata)
  );

  // Level crossing against the previously written sample.
  always_comb begin
    if (edge_q == EDGE_FALL) level_hit_c = prev_vld_q && (prev_q >= level_q) && (iData < level_q);
    else                     level_hit_c = prev_vld_q && (prev_q < level_q) && (iData >= level_q);
  end

  // s1 is the RAM output stage; it moves into the output register whenever that is free.
  assign hs_c   = out_vld_q && iData_Ready;
  assign move_c = s1_vld_q && (!out_vld_q || iData_Ready);

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    level_d    = level_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    pre_d      = pre_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    force_d    = force_q;
    trig_d     = trig_q;
    rd_cnt_d   = rd_cnt_q;
    hs_cnt_d   = hs_cnt_q;
    s1_vld_d   = s1_vld_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    we_c       = 1'b0;
    re_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iArm) begin
          edge_d     = iEdge;
          level_d    = iLevel;
          pre_d      = iPreCnt;  // pAddrBits wide, so already within 0..N-1
          wr_ptr_d   = '0;
          cnt_d      = '0;
          prev_vld_d = 1'b0;
          force_d    = 1'b0;
          rd_cnt_d   = '0;
          hs_cnt_d   = '0;
          state_d    = S_PRE;
        end
      end

      S_PRE: begin
        if (cnt_q == pre_q) begin
          state_d = S_WAIT;
        end else if (iData_Valid) begin
          we_c       = 1'b1;
          wr_ptr_d   = wr_ptr_q + pAddrBits'(1);
          cnt_d      = cnt_q + pAddrBits'(1);
          prev_d     = iData;
          prev_vld_d = 1'b1;
          if (cnt_d == pre_q) state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (iData_Valid) begin
          we_c       = 1'b1;
          wr_ptr_d   = wr_ptr_q + pAddrBits'(1);
          prev_d     = iData;
          prev_vld_d = 1'b1;
          force_d    = 1'b0;
          if (force_q || iForce || level_hit_c) begin
            trig_d    = 1'b1;
            rd_addr_d = wr_ptr_q - pre_q;
            cnt_d     = ADDR_MAX - pre_q;
            state_d   = (cnt_d == '0) ? S_READ : S_POST;
          end
        end else if (iForce) begin
          force_d = 1'b1;
        end
      end

      S_POST: begin
        if (iData_Valid) begin
          we_c     = 1'b1;
          wr_ptr_d = wr_ptr_q + pAddrBits'(1);
          cnt_d    = cnt_q - pAddrBits'(1);
          if (cnt_q == pAddrBits'(1)) state_d = S_READ;
        end
      end

      S_READ: begin
        re_c = (rd_cnt_q != FRAME_LEN) && (!s1_vld_q || move_c);
        if (re_c) begin
          rd_addr_d = rd_addr_q + pAddrBits'(1);
          rd_cnt_d  = rd_cnt_q + CNT_W'(1);
        end
        if (move_c) out_data_d = ram_rdata;

        if (re_c)        s1_vld_d = 1'b1;
        else if (move_c) s1_vld_d = 1'b0;

        if (move_c)    out_vld_d = 1'b1;
        else if (hs_c) out_vld_d = 1'b0;

        if (hs_c) begin
          hs_cnt_d = hs_cnt_q + CNT_W'(1);
          if (hs_cnt_d == FRAME_LEN) begin
            trig_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      edge_q     <= 1'b0;
      level_q    <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      pre_q      <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      force_q    <= 1'b0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_cnt_q   <= '0;
      hs_cnt_q   <= '0;
      s1_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      level_q    <= level_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      pre_q      <= pre_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      force_q    <= force_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      rd_cnt_q   <= rd_cnt_d;
      hs_cnt_q   <= hs_cnt_d;
      s1_vld_q   <= s1_vld_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign oState      = state_q;
  assign oData       = out_data_q;
  assign oData_Valid = out_vld_q;
  assign oTriggered  = trig_q;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: sample-history reference model checked every cycle plus directed literals.
module tb_scope_capture_ctrl;
  import scope_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int N = 16;

  logic          iClk = 1'b0;
  logic          iRst, iArm, iForce, iEdge;
  logic [DW-1:0] iLevel, iData, oData;
  logic [AW-1:0] iPreCnt;
  logic          iData_Valid, oData_Valid, iData_Ready;
  logic [2:0]    oState;
  logic          oTriggered, oBusy;

  always #5 iClk = ~iClk;

  scope_capture_ctrl #(.pAddrBits(AW), .pDataBits(DW)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iArm        (iArm),
    .iForce      (iForce),
    .iEdge       (iEdge),
    .iLevel      (iLevel),
    .iPreCnt     (iPreCnt),
    .iData       (iData),
    .iData_Valid (iData_Valid),
    .oData       (oData),
    .oData_Valid (oData_Valid),
    .iData_Ready (iData_Ready),
    .oState      (oState),
    .oTriggered  (oTriggered),
    .oBusy       (oBusy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: keeps every sample accepted since arm; the frame is a slice of that history.
  int            m_phase = 0;
  logic          m_edge;
  logic [DW-1:0] m_level;
  int            m_pre, m_tidx, m_post_left, m_age, m_hs;
  bit            m_force, m_fire, m_cross, m_hs_now;
  logic [DW-1:0] m_hist[$];
  logic [DW-1:0] m_frame[$];
  logic          e_trig = 1'b0, e_valid = 1'b0;
  logic [DW-1:0] e_data = '0;
  int            cyc_n = 0;

  function automatic void enter_read();
    m_frame.delete();
    for (int i = 0; i < N; i++) m_frame.push_back(m_hist[m_tidx - m_pre + i]);
    m_age   = 0;
    m_hs    = 0;
    m_phase = 4;
  endfunction

  always @(posedge iClk) begin
    cyc_n++;
    if (iRst) begin
      m_phase = 0;
      m_force = 0;
      e_trig  = 1'b0;
      e_valid = 1'b0;
      e_data  = '0;
    end else begin
      m_hs_now = e_valid && iData_Ready;
      case (m_phase)
        0: if (iArm) begin
          m_edge  = iEdge;
          m_level = iLevel;
          m_pre   = int'(iPreCnt);
          m_hist.delete();
          m_force = 0;
          m_phase = 1;
        end
        1: if (m_hist.size() == m_pre) m_phase = 2;
           else if (iData_Valid) begin
             m_hist.push_back(iData);
             if (m_hist.size() == m_pre) m_phase = 2;
           end
        2: if (iData_Valid) begin
             m_cross = 0;
             if (m_hist.size() > 0)
               m_cross = m_edge ? (m_hist[$] >= m_level && iData < m_level)
                                : (m_hist[$] < m_level && iData >= m_level);
             m_fire = m_cross || m_force || iForce;
             m_hist.push_back(iData);
             m_force = 0;
             if (m_fire) begin
               m_tidx      = m_hist.size() - 1;
               m_post_left = N - 1 - m_pre;
               e_trig      = 1'b1;
               m_phase     = 3;
               if (m_post_left == 0) enter_read();
             end
           end else if (iForce) m_force = 1;
        3: if (iData_Valid) begin
             m_hist.push_back(iData);
             m_post_left--;
             if (m_post_left == 0) enter_read();
           end
        4: begin
          m_age++;
          if (m_hs_now) m_hs++;
          if (m_hs == N) begin
            m_phase = 0;
            e_trig  = 1'b0;
            e_valid = 1'b0;
          end else begin
            e_valid = (m_age >= 2);
            if (e_valid) e_data = m_frame[m_hs];
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare and readout observation on the falling edge.
  bit            chk_en = 0;
  logic [DW-1:0] got_q[$];
  int            t_read, t_valid, t_trig, t_smp;

  always @(negedge iClk) begin
    if (chk_en) begin
      check("state", 32'(oState), 32'(m_phase));
      check("busy", 32'(oBusy), 32'(m_phase != 0));
      check("triggered", 32'(oTriggered), 32'(e_trig));
      check("valid", 32'(oData_Valid), 32'(e_valid));
      if (e_valid) check("data", 32'(oData), 32'(e_data));
      if (oData_Valid && iData_Ready) got_q.push_back(oData);
      if (oState == READ && t_read < 0) t_read = cyc_n;
      if (oData_Valid && t_valid < 0) t_valid = cyc_n;
      if (oTriggered && t_trig < 0) t_trig = cyc_n;
    end
  end

  function automatic logic [DW-1:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic arm(input logic e, input logic [DW-1:0] lvl, input int pre);
    iArm = 1'b1; iEdge = e; iLevel = lvl; iPreCnt = AW'(pre);
    cyc();
    iArm = 1'b0;
  endtask

  task automatic smp(input logic [DW-1:0] d);
    iData = d; iData_Valid = 1'b1;
    cyc();
    iData_Valid = 1'b0;
  endtask

  task automatic drain(input int mode);
    int c = 0;
    while (m_phase != 0 && c < 400) begin
      iData_Ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      cyc();
      c++;
    end
    if (m_phase != 0) begin
      failures++;
      $display("FAIL drain_timeout got=phase%0d exp=idle", m_phase);
    end
    iData_Ready = 1'b1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    t_read = -1; t_valid = -1; t_trig = -1; t_smp = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(oState), 32'(IDLE));
    check({tag, "_data"}, 32'(oData), 32'h0);
    check({tag, "_valid"}, 32'(oData_Valid), 32'h0);
    check({tag, "_trig"}, 32'(oTriggered), 32'h0);
    check({tag, "_busy"}, 32'(oBusy), 32'h0);
  endtask

  initial begin
    iRst = 1'b1; iArm = 1'b0; iForce = 1'b0; iEdge = 1'b0; iLevel = '0; iPreCnt = '0;
    iData = '0; iData_Valid = 1'b0; iData_Ready = 1'b1;
    clear_obs();
    cyc();
    chk_en = 1;
    cyc();
    check_reset_outputs("por");
    iRst = 1'b0;
    cyc();

    // Rising trigger on a ramp; an arm pulse during POST must not restart capture.
    clear_obs();
    arm(EDGE_RISE, 8'h80, 4);
    for (int i = 0; i < 32; i++) begin
      if (i == 22) iArm = 1'b1;
      smp(8'(8'h70 + i));
      iArm = 1'b0;
    end
    drain(0);
    check("rise_count", 32'(got_q.size()), 32'd16);
    check("rise_first", 32'(got_at(0)), 32'h7C);
    check("rise_trig_idx4", 32'(got_at(4)), 32'h80);
    check("rise_last", 32'(got_at(15)), 32'h8B);
    check("rise_read_latency", 32'(t_valid - t_read), 32'd2);

    // Falling trigger on an alternating pattern.
    clear_obs();
    arm(EDGE_FALL, 8'h40, 3);
    smp(8'h50); smp(8'h30); smp(8'h50);
    t_smp = cyc_n;
    smp(8'h30);
    for (int i = 0; i < 20; i++) smp((i % 2 == 0) ? 8'h50 : 8'h30);
    drain(0);
    check("fall_trig_delay", 32'(t_trig - t_smp), 32'd1);
    check("fall_first", 32'(got_at(0)), 32'h50);
    check("fall_trig_idx3", 32'(got_at(3)), 32'h30);
    check("fall_last", 32'(got_at(15)), 32'h30);

    // Force with wrap: force in PRE is ignored, a sticky force in WAIT fires on the next sample.
    clear_obs();
    arm(EDGE_RISE, 8'h80, 15);
    iForce = 1'b1; smp(8'h10); iForce = 1'b0;
    for (int i = 1; i < 40; i++) smp(8'h10);
    iForce = 1'b1; cyc(); iForce = 1'b0;
    t_smp = cyc_n;
    smp(8'h10);
    drain(0);
    check("force_trig_delay", 32'(t_trig - t_smp), 32'd1);
    check("force_direct_read", 32'(t_read - t_trig), 32'd0);
    check("force_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < N; i++) check("force_data", 32'(got_at(i)), 32'h10);

    // Backpressure: readout with a 1-on/2-off ready pattern.
    clear_obs();
    iData_Ready = 1'b0;
    arm(EDGE_RISE, 8'h20, 2);
    for (int i = 0; i < 24; i++) smp(8'(i * 5));
    drain(1);
    check("bp_count", 32'(got_q.size()), 32'd16);
    check("bp_first", 32'(got_at(0)), 32'h19);
    check("bp_trig_idx2", 32'(got_at(2)), 32'h23);
    check("bp_last", 32'(got_at(15)), 32'h64);

    // Reset while waiting for a trigger.
    clear_obs();
    arm(EDGE_RISE, 8'h80, 4);
    for (int i = 0; i < 6; i++) smp(8'(8'h70 + i));
    iRst = 1'b1;
    cyc();
    check_reset_outputs("midrst");
    iRst = 1'b0;
    cyc();

    // Sample in IDLE is ignored, then pre=0 capture puts the trigger sample at index 0.
    clear_obs();
    smp(8'h99);
    arm(EDGE_RISE, 8'h80, 0);
    cyc();
    smp(8'h60);
    smp(8'h90);
    for (int i = 0; i < 15; i++) smp(8'(8'hA0 + i));
    drain(0);
    check("pre0_count", 32'(got_q.size()), 32'd16);
    check("pre0_trig_idx0", 32'(got_at(0)), 32'h90);
    check("pre0_second", 32'(got_at(1)), 32'hA0);
    check("pre0_last", 32'(got_at(15)), 32'hAE);

    repeat (3) cyc();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
